// File: rtl/pc_seq_ctrl_if.sv
// Bundle between the fetch-stage PC register / pipeline and the next-PC sequencer.
// Bit numbering is big-endian: bit 0 is the MSB and bit PC_WIDTH-1 is the LSB.
interface pc_seq_ctrl_if #(
    parameter int PC_WIDTH = 32
);
    logic [0:PC_WIDTH-1] pc_i;
    logic                stall_i;
    logic                br_taken_i;
    logic [0:PC_WIDTH-1] br_target_i;
    logic                exc_req_i;
    logic [0:PC_WIDTH-1] exc_pc_i;
    logic                rfi_i;
    logic                pc_wr_o;
    logic [0:PC_WIDTH-1] npc_o;
    logic                flush_o;
    logic [0:PC_WIDTH-1] srr0_o;
    logic                exc_en_o;
    logic                busy_o;

    modport master (
        output pc_i, stall_i, br_taken_i, br_target_i, exc_req_i, exc_pc_i, rfi_i,
        input  pc_wr_o, npc_o, flush_o, srr0_o, exc_en_o, busy_o
    );

    modport slave (
        input  pc_i, stall_i, br_taken_i, br_target_i, exc_req_i, exc_pc_i, rfi_i,
        output pc_wr_o, npc_o, flush_o, srr0_o, exc_en_o, busy_o
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer and write controller for the fetch-stage PC register:
// boot delay, exception entry/return (SRR0, exception enable) and fetch flush.
module pc_seq_ctrl #(
    parameter int                  PC_WIDTH   = 32,
    parameter logic [0:PC_WIDTH-1] RESET_PC   = 32'h0000_3000,
    parameter logic [0:PC_WIDTH-1] EXC_VECTOR = 32'h0000_0700,
    parameter int                  BOOT_DELAY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        EXC_HOLD = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          boot_cnt;
    logic [0:PC_WIDTH-1] srr0;
    logic                exc_en;

    logic                pc_wr;
    logic                flush;
    logic                busy;
    logic [0:PC_WIDTH-1] npc_raw;
    logic [0:PC_WIDTH-1] seq_pc;
    logic                take_exc;
    logic                take_rfi;

    // Instructions are word aligned: the two LSBs never reach the PC register.
    function automatic logic [0:PC_WIDTH-1] align_pc(input logic [0:PC_WIDTH-1] a);
        return {a[0:PC_WIDTH-3], 2'b00};
    endfunction

    assign seq_pc = bus.pc_i + PC_WIDTH'(4);

    always_comb begin
        pc_wr    = 1'b0;
        flush    = 1'b0;
        busy     = 1'b1;
        npc_raw  = RESET_PC;
        take_exc = 1'b0;
        take_rfi = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    busy = 1'b0;
                    // Redirects override a stall; a masked exception falls through.
                    if (bus.exc_req_i && exc_en) begin
                        take_exc = 1'b1;
                        npc_raw  = EXC_VECTOR;
                        pc_wr    = 1'b1;
                        flush    = 1'b1;
                    end else if (bus.rfi_i) begin
                        take_rfi = 1'b1;
                        npc_raw  = srr0;
                        pc_wr    = 1'b1;
                        flush    = 1'b1;
                    end else if (bus.br_taken_i) begin
                        npc_raw  = bus.br_target_i;
                        pc_wr    = 1'b1;
                        flush    = 1'b1;
                    end else begin
                        npc_raw  = seq_pc;
                        pc_wr    = !bus.stall_i;
                    end
                end
                EXC_HOLD: begin
                    flush   = 1'b1;
                    npc_raw = bus.pc_i;
                end
                default: begin
                    npc_raw = RESET_PC;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= BOOT;
            boot_cnt <= 4'd0;
            srr0     <= '0;
            exc_en   <= 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    boot_cnt <= boot_cnt + 4'd1;
                    if (boot_cnt == 4'(BOOT_DELAY - 1))
                        state <= RUN;
                end
                RUN: begin
                    if (take_exc) begin
                        srr0   <= bus.exc_pc_i;
                        exc_en <= 1'b0;
                        state  <= EXC_HOLD;
                    end else if (take_rfi) begin
                        exc_en <= 1'b1;
                    end
                end
                EXC_HOLD: state <= RUN;
                default:  state <= BOOT;
            endcase
        end
    end

    assign bus.pc_wr_o  = pc_wr;
    assign bus.npc_o    = align_pc(npc_raw);
    assign bus.flush_o  = flush;
    assign bus.busy_o   = busy;
    assign bus.srr0_o   = srr0;
    assign bus.exc_en_o = exc_en;

endmodule
